// File: rtl/debounce_botao_pkg.sv
// rtl/debounce_botao_pkg.sv - shared state encodings and debounce window defaults
package debounce_botao_pkg;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ARMING    = 2'd1;
    localparam logic [1:0] PRESSED   = 2'd2;
    localparam logic [1:0] RELEASING = 2'd3;

    // Short window keeps simulation fast; board builds need 10 ms at 50 MHz.
    localparam int STABLE_CYCLES_SIM   = 4;
    localparam int STABLE_CYCLES_BOARD = 500000;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for asynchronous external switch lines
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic sync_q1_q;
    logic sync_q2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1_q <= 1'b0;
            sync_q2_q <= 1'b0;
        end else begin
            sync_q1_q <= d;
            sync_q2_q <= sync_q1_q;
        end
    end

    assign q = sync_q2_q;

endmodule

// File: rtl/debounce_botao.sv
// rtl/debounce_botao.sv - button debouncer giving a clean level plus press/release pulses
module debounce_botao
    import debounce_botao_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_SIM
) (
    input  logic clk,
    input  logic reset,
    input  logic press_raw,
    output logic press_clean,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_clean_q, press_clean_d;
    logic             press_pulse_q, press_pulse_d;
    logic             release_pulse_q, release_pulse_d;
    logic             cnt_done;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (press_raw),
        .q     (sync_q)
    );

    assign cnt_done = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            press_clean_q   <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            press_clean_q   <= press_clean_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (sync_q) state_d = ARMING;
            ARMING: begin
                if (!sync_q)       state_d = IDLE;
                else if (cnt_done) state_d = PRESSED;
            end
            PRESSED:   if (!sync_q) state_d = RELEASING;
            RELEASING: begin
                if (sync_q)        state_d = PRESSED;
                else if (cnt_done) state_d = IDLE;
            end
            default:   state_d = IDLE;
        endcase
    end

    // The counter restarts on every state change, so it can never pass CNT_LAST.
    always_comb begin
        cnt_d           = '0;
        press_clean_d   = 1'b0;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = sync_q ? CNT_ONE : '0;
            end
            ARMING: begin
                if (sync_q && cnt_done) begin
                    press_clean_d = 1'b1;
                    press_pulse_d = 1'b1;
                end else if (sync_q) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                press_clean_d = 1'b1;
                cnt_d         = sync_q ? '0 : CNT_ONE;
            end
            RELEASING: begin
                press_clean_d = 1'b1;
                if (!sync_q && cnt_done) begin
                    press_clean_d   = 1'b0;
                    release_pulse_d = 1'b1;
                end else if (!sync_q) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    assign press_clean   = press_clean_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;

endmodule

// File: tb/tb_debounce_botao.sv
// tb/tb_debounce_botao.sv - scoreboard bench for debounce_botao with directed button waveforms
module tb_debounce_botao;

    typedef struct {
        int cyc;
        bit is_press;
    } ev_t;

    logic clk;
    logic rst;
    logic raw;
    logic press_clean;
    logic press_pulse;
    logic release_pulse;

    int  cyc;
    int  n_checks;
    int  n_fail;
    int  n_press;
    int  n_release;
    int  toggle_changes;
    bit  toggle_q;
    ev_t exp_q[$];

    debounce_botao #(.STABLE_CYCLES(4)) dut (
        .clk           (clk),
        .reset         (rst),
        .press_raw     (raw),
        .press_clean   (press_clean),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Latency from a raw level change driven here to the pulse edge is 6 posedges.
    task automatic expect_pulse(input bit is_press);
        ev_t e;
        e.cyc      = cyc + 6;
        e.is_press = is_press;
        exp_q.push_back(e);
    endtask

    task automatic hold(input logic v, input int n);
        raw = v;
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (press_pulse && release_pulse)
                check("pulse_exclusive", 32'd1, 32'd0);
            if (press_pulse || release_pulse) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {31'd0, press_pulse}, {31'd0, release_pulse});
                    check("unexpected_pulse_any", 32'd1, 32'd0);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("pulse_cycle", cyc, e.cyc);
                    check("pulse_kind_press", {31'd0, press_pulse}, {31'd0, e.is_press});
                    check("clean_with_pulse", {31'd0, press_clean}, {31'd0, e.is_press});
                end
                if (press_pulse) begin
                    n_press++;
                    toggle_q = ~toggle_q;
                    toggle_changes++;
                end
                if (release_pulse) n_release++;
            end
        end
    end

    initial begin
        cyc = 0; n_checks = 0; n_fail = 0; n_press = 0; n_release = 0;
        toggle_changes = 0; toggle_q = 1'b0;
        rst = 1'b1;
        raw = 1'b1;

        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", {29'd0, press_clean, press_pulse, release_pulse}, 32'd0);
        end
        rst = 1'b0;
        expect_pulse(1'b1);
        hold(1'b1, 10);
        check("press_after_reset", {31'd0, press_clean}, 32'd1);

        expect_pulse(1'b0);
        hold(1'b0, 10);
        check("release_after_reset_press", {31'd0, press_clean}, 32'd0);

        expect_pulse(1'b1);
        hold(1'b1, 4);
        check("clean_press_not_early", {31'd0, press_clean}, 32'd0);
        hold(1'b1, 16);
        check("clean_press_level", {31'd0, press_clean}, 32'd1);

        hold(1'b0, 2);
        hold(1'b1, 10);
        check("release_glitch_level", {31'd0, press_clean}, 32'd1);

        expect_pulse(1'b0);
        hold(1'b0, 10);
        check("clean_release_level", {31'd0, press_clean}, 32'd0);

        hold(1'b1, 1);
        hold(1'b0, 1);
        hold(1'b1, 1);
        hold(1'b0, 1);
        check("bounce_no_press", {31'd0, press_clean}, 32'd0);
        expect_pulse(1'b1);
        hold(1'b1, 15);
        check("bounce_final_level", {31'd0, press_clean}, 32'd1);

        expect_pulse(1'b0);
        hold(1'b0, 10);
        check("bounce_release_level", {31'd0, press_clean}, 32'd0);

        hold(1'b1, 4);
        check("armed_count", {30'd0, dut.cnt_q}, 32'd2);
        check("armed_state", {30'd0, dut.state_q}, 32'd1);
        #2;
        rst = 1'b1;
        raw = 1'b0;
        #1;
        check("midreset_state", {30'd0, dut.state_q}, 32'd0);
        check("midreset_cnt", {30'd0, dut.cnt_q}, 32'd0);
        check("midreset_outputs", {29'd0, press_clean, press_pulse, release_pulse}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        hold(1'b0, 15);
        check("post_reset_idle", {31'd0, press_clean}, 32'd0);

        check("pending_pulses", exp_q.size(), 32'd0);
        check("press_count", n_press, 32'd3);
        check("release_count", n_release, 32'd3);
        check("toggle_changes", toggle_changes, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
